// File: rtl/cnt_updn_mod.sv
// Cascadable up/down modulo counter with synchronous clear/preset/load,
// selectable wrap or saturate at the terminal count, a terminal-count pulse and a sticky overflow flag.
module cnt_updn_mod #(
  parameter int     WIDTH   = 8,
  parameter longint MODULUS = 256,
  parameter bit     SAT     = 1'b0
) (
  input  logic             CLK,
  input  logic             CD,
  input  logic             CLR,
  input  logic             PS,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             EN,
  input  logic             CAI,
  input  logic             UP,
  output logic [WIDTH-1:0] Q,
  output logic             CAO,
  output logic             TC,
  output logic             OVF
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             terminal;
  logic [WIDTH-1:0] d_lim;

  // A full-range counter cannot receive an out-of-range load, so the clamp only exists for short moduli.
  if (MODULUS >= (64'(1) << WIDTH)) begin : g_full
    assign d_lim = D;
  end else begin : g_clamp
    assign d_lim = (D > MAX_V) ? MAX_V : D;
  end

  assign step     = CAI & EN;
  assign terminal = UP ? (q_q == MAX_V) : (q_q == '0);
  assign CAO      = step & terminal;

  always_comb begin
    q_d   = q_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (CLR) begin
      q_d   = '0;
      ovf_d = 1'b0;
    end else if (PS) begin
      q_d = MAX_V;
    end else if (LD) begin
      q_d = d_lim;
    end else if (step) begin
      if (!terminal) begin
        q_d = UP ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
      end else begin
        // Saturating mode simply leaves q_d at the bound.
        if (!SAT) begin
          q_d = UP ? '0 : MAX_V;
        end
        tc_d  = 1'b1;
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge CD) begin
    if (CD) begin
      q_q   <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign Q   = q_q;
  assign TC  = tc_q;
  assign OVF = ovf_q;

endmodule

// File: tb/tb_cnt_updn_mod.sv
// Directed bench for cnt_updn_mod: wrap and saturate instances, a BCD chain pair and a full-range default instance.
module tb_cnt_updn_mod;

  logic       CLK = 1'b0;
  logic       CD  = 1'b1;
  logic       clr = 1'b0, ps = 1'b0, ld = 1'b0, en = 1'b0, cai = 1'b0, up = 1'b0;
  logic [3:0] d   = '0;

  logic [3:0] q_w, q_s;
  logic       cao_w, tc_w, ovf_w, cao_s, tc_s, ovf_s;

  logic       c_en = 1'b0;
  logic       c_zero = 1'b0;
  logic [3:0] q_lo, q_hi;
  logic       cao_lo, tc_lo, ovf_lo, cao_hi, tc_hi, ovf_hi;

  logic       f_en = 1'b0, f_up = 1'b0;
  logic [7:0] q_f;
  logic       cao_f, tc_f, ovf_f;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  cnt_updn_mod #(.WIDTH(4), .MODULUS(10), .SAT(1'b0)) u_w (
    .CLK(CLK), .CD(CD), .CLR(clr), .PS(ps), .LD(ld), .D(d), .EN(en), .CAI(cai), .UP(up),
    .Q(q_w), .CAO(cao_w), .TC(tc_w), .OVF(ovf_w));

  cnt_updn_mod #(.WIDTH(4), .MODULUS(10), .SAT(1'b1)) u_s (
    .CLK(CLK), .CD(CD), .CLR(clr), .PS(ps), .LD(ld), .D(d), .EN(en), .CAI(cai), .UP(up),
    .Q(q_s), .CAO(cao_s), .TC(tc_s), .OVF(ovf_s));

  cnt_updn_mod #(.WIDTH(4), .MODULUS(10), .SAT(1'b0)) u_lo (
    .CLK(CLK), .CD(CD), .CLR(c_zero), .PS(c_zero), .LD(c_zero), .D(4'd0), .EN(c_en), .CAI(c_en), .UP(1'b1),
    .Q(q_lo), .CAO(cao_lo), .TC(tc_lo), .OVF(ovf_lo));

  cnt_updn_mod #(.WIDTH(4), .MODULUS(10), .SAT(1'b0)) u_hi (
    .CLK(CLK), .CD(CD), .CLR(c_zero), .PS(c_zero), .LD(c_zero), .D(4'd0), .EN(c_en), .CAI(cao_lo), .UP(1'b1),
    .Q(q_hi), .CAO(cao_hi), .TC(tc_hi), .OVF(ovf_hi));

  cnt_updn_mod u_f (
    .CLK(CLK), .CD(CD), .CLR(1'b0), .PS(1'b0), .LD(1'b0), .D(8'd0), .EN(f_en), .CAI(f_en), .UP(f_up),
    .Q(q_f), .CAO(cao_f), .TC(tc_f), .OVF(ovf_f));

  typedef struct {
    logic       clr, ps, ld;
    logic [3:0] d;
    logic       en, cai, up;
    logic [3:0] exp_q;
    logic       exp_tc, exp_ovf;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    clr = 0; ps = 0; ld = 0; d = '0; en = 0; cai = 0; up = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //             clr ps ld d   en cai up  q  tc ovf
    vecs[0]  = '{1, 1, 1, 4'd5,  0, 0, 0, 4'd0, 0, 0};
    vecs[1]  = '{0, 1, 1, 4'd5,  0, 0, 0, 4'd9, 0, 0};
    vecs[2]  = '{0, 0, 1, 4'd13, 0, 0, 0, 4'd9, 0, 0};
    vecs[3]  = '{0, 0, 1, 4'd3,  0, 0, 0, 4'd3, 0, 0};
    vecs[4]  = '{0, 0, 0, 4'd0,  1, 1, 1, 4'd4, 0, 0};
    vecs[5]  = '{0, 0, 0, 4'd0,  1, 0, 1, 4'd4, 0, 0};
    vecs[6]  = '{0, 0, 0, 4'd0,  0, 1, 1, 4'd4, 0, 0};
    vecs[7]  = '{0, 0, 0, 4'd0,  1, 1, 0, 4'd3, 0, 0};
    vecs[8]  = '{0, 0, 1, 4'd0,  0, 0, 0, 4'd0, 0, 0};
    vecs[9]  = '{0, 0, 0, 4'd0,  1, 1, 0, 4'd9, 1, 1};
    vecs[10] = '{0, 0, 0, 4'd0,  1, 1, 0, 4'd8, 0, 1};
    vecs[11] = '{0, 1, 0, 4'd0,  0, 0, 0, 4'd9, 0, 1};
    vecs[12] = '{0, 0, 0, 4'd0,  1, 1, 1, 4'd0, 1, 1};
    vecs[13] = '{0, 0, 1, 4'd9,  0, 0, 0, 4'd9, 0, 1};
    vecs[14] = '{0, 0, 1, 4'd4,  1, 1, 1, 4'd4, 0, 1};
    vecs[15] = '{1, 0, 0, 4'd0,  1, 1, 1, 4'd0, 0, 0};
    vecs[16] = '{0, 0, 0, 4'd0,  1, 1, 1, 4'd1, 0, 0};

    // Reset held: outputs cleared, CAO follows down-mode terminal at Q=0.
    #12;
    chk("rst_q", q_w, 0);
    chk("rst_tc", tc_w, 0);
    chk("rst_ovf", ovf_w, 0);
    chk("rst_q_full", q_f, 0);
    en = 1; cai = 1; up = 0;
    #1 chk("rst_cao_down", cao_w, 1);
    up = 1;
    #1 chk("rst_cao_up", cao_w, 0);
    ld = 1; d = 4'd5;
    tick();
    chk("rst_ignores_sync", q_w, 0);
    idle_inputs();
    #1 CD = 0;
    tick();
    chk("post_rst_hold", q_w, 0);

    for (int i = 0; i < 17; i++) begin
      clr = vecs[i].clr; ps = vecs[i].ps; ld = vecs[i].ld; d = vecs[i].d;
      en = vecs[i].en; cai = vecs[i].cai; up = vecs[i].up;
      tick();
      chk("vec_q", q_w, vecs[i].exp_q);
      chk("vec_tc", tc_w, vecs[i].exp_tc);
      chk("vec_ovf", ovf_w, vecs[i].exp_ovf);
    end

    // Up-wrap through the full 0..9 cycle.
    idle_inputs(); clr = 1;
    tick();
    clr = 0; en = 1; cai = 1; up = 1;
    for (int i = 0; i < 10; i++) begin
      chk("wrap_cao", cao_w, (i == 9));
      tick();
      chk("wrap_q", q_w, (i + 1) % 10);
      chk("wrap_tc", tc_w, (i == 9));
      chk("wrap_ovf", ovf_w, (i == 9));
    end
    en = 0;
    tick();
    chk("wrap_tc_drop", tc_w, 0);
    chk("wrap_ovf_sticky", ovf_w, 1);

    // Down-saturate on the SAT=1 instance.
    idle_inputs(); clr = 1;
    tick();
    clr = 0; ld = 1; d = 4'd2;
    tick();
    chk("sat_load", q_s, 2);
    ld = 0; en = 1; cai = 1; up = 0;
    for (int k = 0; k < 4; k++) begin
      chk("sat_cao", cao_s, (k >= 2));
      tick();
      chk("sat_q", q_s, (k == 0) ? 1 : 0);
      chk("sat_tc", tc_s, (k >= 2));
      chk("sat_ovf", ovf_s, (k >= 2));
    end

    // Async clear between edges, with OVF set and then with TC set.
    idle_inputs(); clr = 1;
    tick();
    clr = 0; ps = 1;
    tick();
    ps = 0; en = 1; cai = 1; up = 1;
    tick();
    en = 0; ld = 1; d = 4'd7;
    tick();
    chk("acl_pre_q", q_w, 7);
    chk("acl_pre_ovf", ovf_w, 1);
    ld = 0;
    #2 CD = 1;
    #1;
    chk("acl_q", q_w, 0);
    chk("acl_ovf", ovf_w, 0);
    chk("acl_tc", tc_w, 0);
    #1 CD = 0;
    ps = 1;
    tick();
    ps = 0; en = 1; cai = 1; up = 1;
    tick();
    chk("acl_tc_pre", tc_w, 1);
    en = 0;
    #2 CD = 1;
    #1 chk("acl_tc_cleared", tc_w, 0);
    ld = 1; d = 4'd5; en = 1; cai = 1; up = 1;
    tick();
    chk("acl_hold_q1", q_w, 0);
    tick();
    chk("acl_hold_q2", q_w, 0);
    chk("acl_hold_tc", tc_w, 0);
    #2 CD = 0;
    tick();
    chk("acl_first_edge_ld", q_w, 5);
    idle_inputs();

    // Full-range default: one down step from 0 wraps to 255.
    f_en = 1; f_up = 0;
    #1 chk("full_cao", cao_f, 1);
    tick();
    chk("full_q", q_f, 255);
    chk("full_tc", tc_f, 1);
    chk("full_ovf", ovf_f, 1);
    f_en = 0;

    // Two-digit BCD chain 00 -> 99 -> 00.
    c_en = 1;
    for (int i = 0; i < 100; i++) begin
      chk("chain_cao_hi", cao_hi, (i == 99));
      tick();
      chk("chain_val", {q_hi, q_lo}, {4'((i + 1) % 100 / 10), 4'((i + 1) % 10)});
    end
    c_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cnt_updn_mod.md
CNT_UPDN_MOD -- requirements
Module: cnt_updn_mod

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: counter width in bits, legal range 1..32.
REQ-002 The block SHALL have parameter MODULUS, default 256: count states 0..MODULUS-1, legal range 2..2**WIDTH.
REQ-003 The block SHALL have parameter SAT, default 0: 0 = wrap at terminal, 1 = saturate at terminal.
REQ-004 The block SHALL have port CLK  input  1  clock, rising-edge active.
REQ-005 The block SHALL have port CD  input  1  clear; asynchronous, active-high.
REQ-006 The block SHALL have port CLR  input  1  synchronous clear to 0.
REQ-007 The block SHALL have port PS  input  1  synchronous preset to MODULUS-1.
REQ-008 The block SHALL have port LD  input  1  synchronous parallel load of D.
REQ-009 The block SHALL have port D  input  WIDTH  parallel load data.
REQ-010 The block SHALL have port EN  input  1  count enable.
REQ-011 The block SHALL have port CAI  input  1  carry/borrow in from the previous stage.
REQ-012 The block SHALL have port UP  input  1  direction: 1 = up, 0 = down.
REQ-013 The block SHALL have port Q  output  WIDTH  counter value.
REQ-014 The block SHALL have port CAO  output  1  carry/borrow out to the next stage; combinational.
REQ-015 The block SHALL have port TC  output  1  registered terminal-count pulse.
REQ-016 The block SHALL have port OVF  output  1  sticky wrap/saturate flag; registered.

Function
REQ-017 The block SHALL use one clock, CLK; reset SHALL be asynchronous and active-high on CD.
REQ-018 The block SHALL define step = CAI & EN, and terminal = (UP ? Q==MODULUS-1 : Q==0).
REQ-019 On each rising CLK edge with CD low, the block SHALL update Q by priority: CLR -> 0; else PS -> MODULUS-1; else LD -> D; else step -> next; else hold.
REQ-020 When LD wins and D >= MODULUS, the block SHALL load MODULUS-1 (clamp), never an out-of-range value.
REQ-021 When step is true and terminal is false, next SHALL be Q+1 if UP, else Q-1.
REQ-022 When step is true, terminal is true and SAT=0, next SHALL be 0 if UP, else MODULUS-1 (wrap).
REQ-023 When step is true, terminal is true and SAT=1, next SHALL be Q (hold at the bound).
REQ-024 CAO SHALL equal step & terminal, combinationally, in both SAT modes, so that stages chain as CAI(n+1) = CAO(n).
REQ-025 TC SHALL be registered high for exactly the cycle after an edge where the count path was taken with step & terminal; it SHALL be 0 after any other edge, including edges where CLR, PS or LD won.
REQ-026 OVF SHALL be set on any edge where TC is set, and SHALL remain set until CLR or CD.
REQ-027 LD and PS SHALL NOT clear OVF.
REQ-028 CLR SHALL clear OVF on the same edge regardless of the other inputs.
REQ-029 A UP change SHALL take effect on the next edge; no pipeline delay is permitted.
REQ-030 Q SHALL never hold a value >= MODULUS under any input sequence.
REQ-031 With MODULUS = 2**WIDTH, arithmetic SHALL be natural modulo-2**WIDTH.
REQ-032 Arithmetic SHALL NOT overflow the internal width: compare against MODULUS-1 before incrementing.

Reset
REQ-033 While CD is high, Q=0, TC=0 and OVF=0 immediately, independent of CLK; synchronous inputs SHALL be ignored.
REQ-034 CAO SHALL evaluate as CAI & EN & !UP while CD is high, because Q=0 is terminal in down mode.
REQ-035 On CD deassertion, the first rising edge SHALL apply normal priority.
REQ-036 CD asserted mid-count SHALL abort the count with no partial update; TC SHALL be cleared even if it was high.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-037 The bench SHALL cover up-wrap: SAT=0, UP=1, CAI=EN=1 from Q=0 for 10 edges -> Q 1..9,0; CAO high while Q=9; TC high one cycle after Q returns to 0; OVF=1 thereafter.
REQ-038 The bench SHALL cover down-saturate: SAT=1, UP=0, LD D=2 then count 4 edges -> Q 2,1,0,0,0; TC pulses after each of the last two count edges; OVF=1.
REQ-039 The bench SHALL cover priority: CLR=PS=LD=1, D=5 on one edge -> Q=0, OVF=0; then PS=LD=1 -> Q=9; then LD=1, D=13 -> Q=9 (clamped).
REQ-040 The bench SHALL cover the chain: two instances with WIDTH=4, MODULUS=10, CAI(high)=CAO(low), UP=1, 100 edges from 00 -> BCD 99 then 00; high-stage CAO high exactly when the pair reads 99.
REQ-041 The bench SHALL cover async clear: CD pulsed between edges while Q=7, OVF=1 -> Q=0, OVF=0, TC=0 before the next edge; no change on edges while CD is held.
REQ-042 The bench SHALL cover a full-range default: WIDTH=8, MODULUS=256, UP=0 from Q=0 with one step -> Q=255, CAO high during that cycle, OVF=1.
